// File: rtl/cpu_paddle_driver.sv
// Computer-controlled Pong paddle: follows the ball once it has been approaching
// for a few ticks, otherwise parks the paddle in the middle of the playfield.
module cpu_paddle_driver #(
  parameter int SIDE        = 1,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_LEN  = 80,
  parameter int DEADBAND    = 4,
  parameter int REACT_TICKS = 3,
  parameter int JUMP_TH     = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic [9:0] ball_x_i,
  input  logic [9:0] ball_y_i,
  input  logic [9:0] paddle_y_i,
  output logic       up_o,
  output logic       down_o,
  output logic [1:0] state_o,
  output logic       approaching_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CENTER = 2'd1,
    WAIT   = 2'd2,
    TRACK  = 2'd3
  } state_e;

  localparam logic signed [10:0] HALF_LEN   = 11'(PADDLE_LEN / 2);
  localparam logic signed [10:0] MAX_TOP    = 11'(SCREEN_H - PADDLE_LEN);
  localparam logic signed [10:0] CENTER_Y   = 11'((SCREEN_H - PADDLE_LEN) / 2);
  localparam logic signed [10:0] DB         = 11'(DEADBAND);
  localparam logic        [10:0] JUMP_LIM   = 11'(JUMP_TH);
  localparam logic        [7:0]  REACT_LAST = 8'((REACT_TICKS > 0) ? REACT_TICKS - 1 : 0);

  state_e      state_q, state_d;
  logic [9:0]  prev_x_q, prev_x_d;
  logic        prev_valid_q, prev_valid_d;
  logic        appr_q, appr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        up_q, up_d;
  logic        down_q, down_d;

  logic signed [10:0] dx, trk_raw, trk_target, target, pad;
  logic        [10:0] abs_dx;
  logic               jump, has_target;

  always_comb begin
    dx      = $signed({1'b0, ball_x_i}) - $signed({1'b0, prev_x_q});
    abs_dx  = dx[10] ? 11'(-dx) : 11'(dx);
    jump    = prev_valid_q && (abs_dx > JUMP_LIM);
    pad     = $signed({1'b0, paddle_y_i});
    trk_raw = $signed({1'b0, ball_y_i}) - HALF_LEN;
    if (trk_raw < 11'sd0)
      trk_target = 11'sd0;
    else if (trk_raw > MAX_TOP)
      trk_target = MAX_TOP;
    else
      trk_target = trk_raw;
  end

  // Commands are derived from the state being entered, so they appear one clk after the tick.
  always_comb begin
    state_d      = state_q;
    prev_x_d     = prev_x_q;
    prev_valid_d = prev_valid_q;
    appr_d       = appr_q;
    cnt_d        = cnt_q;
    up_d         = up_q;
    down_d       = down_q;
    target       = CENTER_Y;
    has_target   = 1'b0;

    if (!enable_i) begin
      state_d      = IDLE;
      prev_valid_d = 1'b0;
      appr_d       = 1'b0;
      cnt_d        = 8'd0;
      up_d         = 1'b0;
      down_d       = 1'b0;
    end else if (tick_i) begin
      prev_x_d     = ball_x_i;
      prev_valid_d = 1'b1;
      if (state_q == IDLE) begin
        state_d      = CENTER;
        prev_valid_d = 1'b0;
        appr_d       = 1'b0;
        cnt_d        = 8'd0;
      end else if (jump) begin
        state_d      = CENTER;
        prev_valid_d = 1'b0;
        appr_d       = 1'b0;
        cnt_d        = 8'd0;
      end else begin
        if (prev_valid_q && (dx != 11'sd0))
          appr_d = (SIDE == 0) ? dx[10] : !dx[10];
        case (state_q)
          CENTER: begin
            if (appr_d) begin
              cnt_d   = 8'd0;
              state_d = (REACT_TICKS == 0) ? TRACK : WAIT;
            end
          end
          WAIT: begin
            if (!appr_d) begin
              state_d = CENTER;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
              if ((cnt_q + 8'd1) >= REACT_LAST)
                state_d = TRACK;
            end
          end
          TRACK: begin
            if (!appr_d)
              state_d = CENTER;
          end
          default: ;
        endcase
      end

      if (state_d == TRACK) begin
        target     = trk_target;
        has_target = 1'b1;
      end else if (state_d == CENTER) begin
        target     = CENTER_Y;
        has_target = 1'b1;
      end
      up_d   = has_target && (target < pad - DB) && (paddle_y_i != 10'd0);
      down_d = has_target && (target > pad + DB) && (pad < MAX_TOP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      prev_x_q     <= 10'd0;
      prev_valid_q <= 1'b0;
      appr_q       <= 1'b0;
      cnt_q        <= 8'd0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_x_q     <= prev_x_d;
      prev_valid_q <= prev_valid_d;
      appr_q       <= appr_d;
      cnt_q        <= cnt_d;
      up_q         <= up_d;
      down_q       <= down_d;
    end
  end

  assign up_o          = up_q;
  assign down_o        = down_q;
  assign state_o       = state_q;
  assign approaching_o = appr_q;

endmodule

// File: tb/tb_cpu_paddle_driver.sv
// Directed bench for cpu_paddle_driver at default parameters (right-hand paddle).
// Observed vector is {state, up, down, approaching}.
module tb_cpu_paddle_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       enable;
  logic [9:0] ballX, ballY, paddleY;
  logic       up, down, approaching;
  logic [1:0] state;
  int         testsRun = 0;
  int         testsFailed = 0;

  cpu_paddle_driver dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tick_i       (tick),
    .enable_i     (enable),
    .ball_x_i     (ballX),
    .ball_y_i     (ballY),
    .paddle_y_i   (paddleY),
    .up_o         (up),
    .down_o       (down),
    .state_o      (state),
    .approaching_o(approaching)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obsVec();
    return {state, up, down, approaching};
  endfunction

  // Expected vector builder: state, up, down, approaching
  function automatic logic [4:0] ex(input int s, input logic u, input logic d, input logic a);
    return {2'(s), u, d, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state/up/down/appr=%b expected %b", tag, observed, expected);
    end
  endtask

  // Drives one clock of inputs right after an edge; returns #1 after the next edge.
  task automatic applyStimulus(input logic t, input logic en, input int bx, input int by, input int py);
    tick    = t;
    enable  = en;
    ballX   = 10'(bx);
    ballY   = 10'(by);
    paddleY = 10'(py);
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; enable = 1'b1;
    ballX = 10'd500; ballY = 10'd50; paddleY = 10'd300;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset", obsVec(), ex(0, 0, 0, 0));

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 100 + 30 * i, $urandom_range(0, 479), 300);
      checkOutput($sformatf("idle_tick%0d", i), obsVec(), ex(0, 0, 0, 0));
    end

    // Centering with the ball moving away (x decreasing on the right-hand side)
    applyStimulus(1'b1, 1'b1, 400, 240, 300);
    applyStimulus(1'b1, 1'b1, 396, 240, 300);
    checkOutput("center_up", obsVec(), ex(1, 1, 0, 0));
    applyStimulus(1'b1, 1'b1, 392, 240, 202);
    checkOutput("center_deadband", obsVec(), ex(1, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 392, 240, 300);
    checkOutput("no_tick_hold", obsVec(), ex(1, 0, 0, 0));

    // Reaction delay: three approaching ticks before tracking
    applyStimulus(1'b1, 1'b1, 396, 100, 200);
    checkOutput("react_wait1", obsVec(), ex(2, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 400, 100, 200);
    checkOutput("react_wait2", obsVec(), ex(2, 0, 0, 1));
    applyStimulus(1'b0, 1'b1, 400, 100, 200);
    checkOutput("react_gap", obsVec(), ex(2, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 404, 100, 200);
    checkOutput("react_track", obsVec(), ex(3, 1, 0, 1));

    // Target clamp at the bottom (400) and top (0)
    applyStimulus(1'b1, 1'b1, 408, 470, 400);
    checkOutput("clamp_bottom_edge", obsVec(), ex(3, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 412, 470, 398);
    checkOutput("clamp_bottom_sat", obsVec(), ex(3, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 416, 470, 395);
    checkOutput("clamp_bottom_down", obsVec(), ex(3, 0, 1, 1));
    applyStimulus(1'b1, 1'b1, 420, 10, 0);
    checkOutput("clamp_top_edge", obsVec(), ex(3, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 424, 10, 3);
    checkOutput("clamp_top_sat", obsVec(), ex(3, 0, 0, 1));
    applyStimulus(1'b1, 1'b1, 428, 10, 5);
    checkOutput("clamp_top_up", obsVec(), ex(3, 1, 0, 1));

    // Large steps: dx = 60 and dx = 64 are still motion, dx = -280 is a serve jump
    applyStimulus(1'b1, 1'b1, 488, 100, 200);
    checkOutput("step60", obsVec(), ex(3, 1, 0, 1));
    applyStimulus(1'b1, 1'b1, 552, 100, 200);
    checkOutput("step64_limit", obsVec(), ex(3, 1, 0, 1));
    applyStimulus(1'b1, 1'b1, 600, 100, 200);
    checkOutput("step48", obsVec(), ex(3, 1, 0, 1));
    applyStimulus(1'b1, 1'b1, 320, 100, 200);
    checkOutput("jump_center", obsVec(), ex(1, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 324, 100, 200);
    checkOutput("jump_reload", obsVec(), ex(1, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 328, 100, 200);
    checkOutput("jump_redirect", obsVec(), ex(2, 0, 0, 1));

    // Back into tracking, then drop enable without a tick
    applyStimulus(1'b1, 1'b1, 332, 100, 200);
    applyStimulus(1'b1, 1'b1, 336, 100, 200);
    checkOutput("retrack", obsVec(), ex(3, 1, 0, 1));
    applyStimulus(1'b0, 1'b0, 336, 100, 200);
    checkOutput("enable_drop", obsVec(), ex(0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 336, 100, 200);
    checkOutput("enable_no_tick", obsVec(), ex(0, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 340, 100, 300);
    checkOutput("reenable_center", obsVec(), ex(1, 1, 0, 0));
    applyStimulus(1'b1, 1'b1, 344, 100, 300);
    checkOutput("reenable_load", obsVec(), ex(1, 1, 0, 0));
    applyStimulus(1'b1, 1'b1, 348, 100, 300);
    checkOutput("reenable_dir", obsVec(), ex(2, 0, 0, 1));

    // Reset dominates an active enable/tick
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 352, 100, 300);
    checkOutput("reset_wins", obsVec(), ex(0, 0, 0, 0));
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
